// File: rtl/nanov_seq_pkg.sv
// Shared types and helpers for the nanoV serial sequencer.
// Holds the FSM state encoding and the beat-counter width calculation.
package nanov_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } seq_state_e;

  function automatic int count_width(input int xlen, input int bits_per_clk);
    return $clog2(xlen / bits_per_clk);
  endfunction

endpackage

// File: rtl/nanov_deser.sv
// Deserialiser: collects LSB-first result digits into a word and
// publishes the word, with a one-clock valid pulse, on each last beat.
module nanov_deser
  import nanov_seq_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BITS_PER_CLK = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    last_beat,
  input  logic [BITS_PER_CLK-1:0] data_in,
  output logic [XLEN-1:0]         data_word,
  output logic                    word_valid
);

  logic [XLEN-1:0] shift_q, shift_d;
  logic [XLEN-1:0] data_word_q, data_word_d;
  logic            word_valid_q, word_valid_d;

  always_comb begin
    shift_d      = shift_q;
    data_word_d  = data_word_q;
    word_valid_d = 1'b0;
    if (en) begin
      // New digit enters at the top; oldest digit falls off the bottom.
      shift_d = XLEN'({data_in, shift_q} >> BITS_PER_CLK);
      if (last_beat) begin
        data_word_d  = shift_d;
        word_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q      <= '0;
      data_word_q  <= '0;
      word_valid_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      data_word_q  <= data_word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign data_word  = data_word_q;
  assign word_valid = word_valid_q;

endmodule

// File: rtl/nanov_serial_sequencer.sv
// Instruction sequencer for digit-serial nanoV cores: issues instructions,
// drives beat/cycle indices, and deserialises the result stream.
module nanov_serial_sequencer
  import nanov_seq_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BITS_PER_CLK = 1,
  parameter int CYC_W        = 3,
  localparam int COUNT_W     = count_width(XLEN, BITS_PER_CLK)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [31:0]             instr_in,
  input  logic [CYC_W-1:0]        num_cycles_in,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic                    stall,
  input  logic [BITS_PER_CLK-1:0] data_in,
  output logic [31:0]             instr,
  output logic [COUNT_W-1:0]      counter,
  output logic [CYC_W-1:0]        cycle,
  output logic                    first_beat,
  output logic                    last_beat,
  output logic                    busy,
  output logic [XLEN-1:0]         data_word,
  output logic                    word_valid
);

  seq_state_e         state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [CYC_W-1:0]   ncyc_q, ncyc_d;
  logic [COUNT_W-1:0] counter_q, counter_d;
  logic [CYC_W-1:0]   cycle_q, cycle_d;

  logic               busy_w;
  logic               last_beat_w;
  logic               last_cycle_w;
  logic [CYC_W-1:0]   final_cycle_w;
  logic               accept_w;
  logic               advance_w;

  assign busy_w        = (state_q == EXEC);
  assign last_beat_w   = busy_w && (counter_q == {COUNT_W{1'b1}});
  // A zero cycle count runs as a single cycle.
  assign final_cycle_w = (ncyc_q == '0) ? '0 : CYC_W'(ncyc_q - 1'b1);
  assign last_cycle_w  = (cycle_q == final_cycle_w);
  assign advance_w     = busy_w && !stall;
  // Ready depends only on state and stall, never on instr_valid.
  assign instr_ready   = !busy_w || (last_beat_w && last_cycle_w && !stall);
  assign accept_w      = instr_valid && instr_ready;

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    ncyc_d    = ncyc_q;
    counter_d = counter_q;
    cycle_d   = cycle_q;
    if (accept_w) begin
      state_d   = EXEC;
      instr_d   = instr_in;
      ncyc_d    = num_cycles_in;
      counter_d = '0;
      cycle_d   = '0;
    end else if (advance_w) begin
      counter_d = counter_q + 1'b1;
      if (last_beat_w) begin
        if (last_cycle_w) begin
          state_d = IDLE;
          cycle_d = '0;
        end else begin
          cycle_d = cycle_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      ncyc_q    <= '0;
      counter_q <= '0;
      cycle_q   <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      ncyc_q    <= ncyc_d;
      counter_q <= counter_d;
      cycle_q   <= cycle_d;
    end
  end

  nanov_deser #(
    .XLEN        (XLEN),
    .BITS_PER_CLK(BITS_PER_CLK)
  ) u_deser (
    .clk       (clk),
    .rstn      (rstn),
    .en        (advance_w),
    .last_beat (last_beat_w),
    .data_in   (data_in),
    .data_word (data_word),
    .word_valid(word_valid)
  );

  assign instr      = instr_q;
  assign counter    = counter_q;
  assign cycle      = cycle_q;
  assign busy       = busy_w;
  assign first_beat = busy_w && (counter_q == '0);
  assign last_beat  = last_beat_w;

endmodule
